// File: rtl/dac_sample_buffer_pkg.sv
// Shared types and constants for the DAC sample buffer: FSM state encoding,
// default sample width and the mid-scale code helper.
package dac_sample_buffer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   localparam int DAC_WIDTH = 13;

   // Offset-binary zero: only the MSB set.
   function automatic int mid_scale(input int w);
      return 1 << (w - 1);
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO holding {I,Q} words; head is presented combinationally on rdata.
// Pointers wrap naturally at DEPTH (power of two); count is one bit wider than the pointers.
module sample_fifo #(
   parameter int W     = 26,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;

   // Storage is not reset; validity is tracked by cnt alone.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign rdata = mem[rd_ptr];
   assign count = cnt;
   assign full  = (cnt == (AW+1)'(DEPTH));
   assign empty = (cnt == '0);

endmodule

// File: rtl/dac_sample_buffer.sv
// Buffers generator I/Q samples and replays them to the DAC at one sample per DIV clocks.
// Build macro DAC_OFFSET_BINARY_EN selects offset-binary DAC codes (MSB inverted, mid-scale idle).
//
// state  | meaning
// IDLE   | waiting for start; generator disabled; DAC outputs hold
// RUN    | accepting samples while not full; playback once PREFILL reached
// DRAIN  | generator done; playback continues until the FIFO is empty
// FINISH | one cycle: enable releases the generator, frame_done pulses
module dac_sample_buffer
   import dac_sample_buffer_pkg::*;
#(
   parameter int WIDTH   = DAC_WIDTH,
   parameter int DEPTH   = 16,
   parameter int DIV     = 16,
   parameter int PREFILL = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             gen_valid,
   input  logic [WIDTH-1:0] gen_i,
   input  logic [WIDTH-1:0] gen_q,
   input  logic             gen_done,
   output logic             gen_enable,
   output logic [WIDTH-1:0] dac_i,
   output logic [WIDTH-1:0] dac_q,
   output logic             dac_strobe,
   output logic             underrun,
   output logic             busy,
   output logic             frame_done
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int DW = $clog2(DIV);

`ifdef DAC_OFFSET_BINARY_EN
   localparam logic [WIDTH-1:0] IDLE_CODE = WIDTH'(mid_scale(WIDTH));
`else
   localparam logic [WIDTH-1:0] IDLE_CODE = '0;
`endif

   function automatic logic [WIDTH-1:0] to_dac(input logic [WIDTH-1:0] s);
`ifdef DAC_OFFSET_BINARY_EN
      return {~s[WIDTH-1], s[WIDTH-2:0]};
`else
      return s;
`endif
   endfunction

   state_t               state;
   state_t               state_nxt;
   logic                 armed;
   logic [DW-1:0]        div_cnt;
   logic [CW-1:0]        count;
   logic                 full;
   logic                 empty;
   logic [2*WIDTH-1:0]   head;
   logic                 push;
   logic                 pop;
   logic                 playing;
   logic                 tick;
   logic                 starve;

   assign playing = armed && (state == ST_RUN || state == ST_DRAIN);
   assign tick    = playing && (div_cnt == DW'(DIV - 1));
   assign pop     = tick && !empty;
   // An empty tick is an underrun even if a push lands in the same cycle.
   assign starve  = tick && empty && (state == ST_RUN);
   assign push    = gen_valid && gen_enable && (state == ST_RUN) && !gen_done;
   assign busy    = (state != ST_IDLE);

   sample_fifo #(
      .W     (2 * WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .wdata   ({gen_i, gen_q}),
      .pop     (pop),
      .rdata   (head),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   always_comb begin
      state_nxt  = state;
      gen_enable = 1'b0;
      frame_done = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            gen_enable = !full;
            if (gen_done) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (empty) begin
               state_nxt = ST_FINISH;
            end
         end
         ST_FINISH: begin
            gen_enable = 1'b1;
            frame_done = 1'b1;
            state_nxt  = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         armed <= 1'b0;
      end else if (state == ST_IDLE) begin
         armed <= 1'b0;
      end else if (state == ST_RUN && (gen_done || count >= CW'(PREFILL))) begin
         armed <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
      end else if (!playing || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dac_i      <= '0;
         dac_q      <= '0;
         dac_strobe <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         dac_strobe <= pop || starve;
         if (pop) begin
            dac_i <= to_dac(head[2*WIDTH-1:WIDTH]);
            dac_q <= to_dac(head[WIDTH-1:0]);
         end else if (starve) begin
            dac_i <= IDLE_CODE;
            dac_q <= IDLE_CODE;
         end
         if (starve) begin
            underrun <= 1'b1;
         end else if (state == ST_IDLE && start) begin
            underrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dac_sample_buffer.sv
// Randomized directed bench for dac_sample_buffer: a generator model feeds samples and a
// queue-based reference predicts every DAC strobe, spacing, underrun and frame boundary.
module tb_dac_sample_buffer;

   localparam int WIDTH   = 13;
   localparam int DEPTH   = 16;
   localparam int DIV     = 16;
   localparam int PREFILL = 8;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             start = 1'b0;
   logic             gen_valid = 1'b0;
   logic [WIDTH-1:0] gen_i = '0;
   logic [WIDTH-1:0] gen_q = '0;
   logic             gen_done = 1'b0;
   logic             gen_enable;
   logic [WIDTH-1:0] dac_i;
   logic [WIDTH-1:0] dac_q;
   logic             dac_strobe;
   logic             underrun;
   logic             busy;
   logic             frame_done;

   always #5 clk = ~clk;

   dac_sample_buffer #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .DIV     (DIV),
      .PREFILL (PREFILL)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .gen_valid  (gen_valid),
      .gen_i      (gen_i),
      .gen_q      (gen_q),
      .gen_done   (gen_done),
      .gen_enable (gen_enable),
      .dac_i      (dac_i),
      .dac_q      (dac_q),
      .dac_strobe (dac_strobe),
      .underrun   (underrun),
      .busy       (busy),
      .frame_done (frame_done)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // DAC code of a two's complement sample: offset binary adds half of full scale.
   function automatic logic [WIDTH-1:0] dac_code(input logic [WIDTH-1:0] s);
`ifdef DAC_OFFSET_BINARY_EN
      return WIDTH'(int'(s) + (2 ** (WIDTH - 1)));
`else
      return s;
`endif
   endfunction

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic               gen_push_ok = 1'b0;
   logic               push_seen = 1'b0;
   logic [2*WIDTH-1:0] push_word = '0;
   always @(posedge clk) begin
      push_seen <= gen_valid && gen_push_ok && reset_n;
      push_word <= {gen_i, gen_q};
   end

   logic [2*WIDTH-1:0] exp_q[$];
   int  data_strobes = 0;
   int  idle_strobes = 0;
   int  frame_dones  = 0;
   int  max_occ      = 0;
   int  last_strobe  = -1;
   int  first_strobe = -1;
   int  done_cyc     = 0;
   bit  chk_full     = 1'b0;

   // Reference: strobes see FIFO contents from before the edge, then that edge's push is added.
   initial begin
      logic [2*WIDTH-1:0] w;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            exp_q.delete();
            last_strobe = -1;
         end else begin
            if (dac_strobe) begin
               if (last_strobe >= 0) check("strobe_spacing", cyc - last_strobe, DIV);
               else first_strobe = cyc;
               last_strobe = cyc;
               if (exp_q.size() > 0) begin
                  w = exp_q.pop_front();
                  check("dac_i", dac_i, dac_code(w[2*WIDTH-1:WIDTH]));
                  check("dac_q", dac_q, dac_code(w[WIDTH-1:0]));
                  data_strobes++;
               end else begin
                  check("underrun_dac_i", dac_i, dac_code('0));
                  check("underrun_flag", underrun, 1);
                  idle_strobes++;
               end
            end
            if (push_seen) exp_q.push_back(push_word);
            if (exp_q.size() > max_occ) max_occ = exp_q.size();
            if (chk_full && exp_q.size() == DEPTH) check("enable_while_full", gen_enable, 0);
            if (frame_done) begin
               frame_dones++;
               check("finish_enable", gen_enable, 1);
               last_strobe = -1;
            end
         end
      end
   end

   task automatic send(input int n, input int gap_min, input int gap_max);
      for (int k = 0; k < n; k++) begin
         int budget;
         repeat ($urandom_range(gap_max, gap_min)) @(negedge clk);
         budget = 3000;
         while (!gen_enable && budget > 0) begin
            @(negedge clk);
            budget--;
         end
         if (!gen_enable) begin
            check("gen_enable_wait", gen_enable, 1);
            return;
         end
         gen_i       = WIDTH'($urandom);
         gen_q       = WIDTH'($urandom);
         gen_valid   = 1'b1;
         gen_push_ok = 1'b1;
         @(negedge clk);
         gen_valid   = 1'b0;
         gen_push_ok = 1'b0;
      end
   endtask

   task automatic begin_frame();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("underrun_cleared", underrun, 0);
   endtask

   task automatic finish_frame();
      int budget;
      budget   = 5000;
      gen_done = 1'b1;
      done_cyc = cyc + 1;
      while (!frame_done && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("frame_done_seen", frame_done, 1);
      gen_done = 1'b0;
      @(negedge clk);
      check("enable_after_finish", gen_enable, 0);
      check("frame_done_width", frame_done, 0);
      check("idle_after_finish", busy, 0);
   endtask

   initial begin
      int d0, i0, f0;
      // 1. reset with a valid held: nothing moves
      reset_n   = 1'b0;
      gen_valid = 1'b1;
      gen_i     = WIDTH'($urandom);
      repeat (3) @(negedge clk);
      check("rst_dac_i", dac_i, 0);
      check("rst_dac_q", dac_q, 0);
      check("rst_strobe", dac_strobe, 0);
      check("rst_underrun", underrun, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_enable", gen_enable, 0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_enable", gen_enable, 0);
      check("idle_busy", busy, 0);
      check("idle_strobe", dac_strobe, 0);
      gen_valid = 1'b0;

      // 2. nominal frame of 20 samples
      d0 = data_strobes; i0 = idle_strobes; f0 = frame_dones;
      begin_frame();
      send(20, 1, 3);
      finish_frame();
      check("nominal_data", data_strobes - d0, 20);
      check("nominal_idle", idle_strobes - i0, 0);
      check("nominal_frames", frame_dones - f0, 1);
      check("nominal_underrun", underrun, 0);

      // 3. backpressure: a valid every 6 clocks, 100 samples
      d0 = data_strobes; i0 = idle_strobes;
      max_occ = 0;
      begin_frame();
      chk_full = 1'b1;
      send(100, 5, 5);
      chk_full = 1'b0;
      finish_frame();
      check("bp_data", data_strobes - d0, 100);
      check("bp_idle", idle_strobes - i0, 0);
      check("bp_max_occ", max_occ, DEPTH);

      // 4. underrun: 8 samples, 200-clock stall, then more
      d0 = data_strobes; i0 = idle_strobes;
      begin_frame();
      send(8, 1, 2);
      repeat (200) @(negedge clk);
      send(6, 1, 2);
      finish_frame();
      check("ur_data", data_strobes - d0, 14);
      check("ur_idle_seen", (idle_strobes - i0) > 0, 1);
      check("ur_sticky", underrun, 1);
      repeat (5) @(negedge clk);
      check("ur_sticky_idle", underrun, 1);

      // 5. short frame below PREFILL; start also clears underrun
      d0 = data_strobes; i0 = idle_strobes;
      begin_frame();
      send(3, 1, 2);
      finish_frame();
      check("short_data", data_strobes - d0, 3);
      check("short_idle", idle_strobes - i0, 0);
      check("short_latency", first_strobe - done_cyc, DIV);

      // 6. asynchronous reset mid-frame, then a clean frame
      begin_frame();
      send(5, 1, 2);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_dac_i", dac_i, 0);
      check("mid_rst_dac_q", dac_q, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_enable", gen_enable, 0);
      @(negedge clk);
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", busy, 0);
      d0 = data_strobes; i0 = idle_strobes; f0 = frame_dones;
      begin_frame();
      send(4, 1, 3);
      finish_frame();
      check("post_rst_data", data_strobes - d0, 4);
      check("post_rst_idle", idle_strobes - i0, 0);
      check("post_rst_frames", frame_dones - f0, 1);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
